// File: rtl/io_bus_bridge.sv
// Byte-wide CPU memory-port bridge: RAM/I/O decode, two-cycle read alignment,
// UART TX FIFO, free-running cycle counter with snapshot, and sticky program stop.
module io_bus_bridge #(
    parameter int TX_DEPTH_LOG2 = 3,
    parameter int RAM_ADDR_W    = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [31:0]           mem_addr,
    input  logic [7:0]            mem_dout,
    input  logic                  mem_wr,
    input  logic                  mem_re,
    output logic [7:0]            mem_din,
    output logic                  cpu_rdy_o,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [7:0]            ram_din,
    output logic                  ram_we,
    input  logic [7:0]            ram_dout,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_pop,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  halted_o
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam logic [TX_DEPTH_LOG2:0] TX_FULL_CNT = (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);

    logic                     sel_io_q, sel_io_d;
    logic [7:0]               io_byte_q, io_byte_d;
    logic [31:0]              cyc_cnt_q, cyc_cnt_d;
    logic [31:0]              snap_q, snap_d;
    logic                     halted_q, halted_d;
    logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [TX_DEPTH_LOG2-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_DEPTH_LOG2:0]   tx_count_q, tx_count_d;
    logic [7:0]               tx_mem_q [TX_DEPTH];
    logic [7:0]               tx_mem_d [TX_DEPTH];

    logic       is_io;
    logic [2:0] io_off;
    logic       wr_io;
    logic       uart_rd;
    logic       rx_stall;
    logic       stop_req;
    logic       push_req;
    logic       tx_full;
    logic       tx_full_stall;
    logic       tx_push;
    logic       tx_pop;
    logic [7:0] push_byte;
    logic [7:0] io_byte;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[31:18];

    assign ram_addr = mem_addr[RAM_ADDR_W-1:0];
    assign ram_din  = mem_dout;
    assign mem_din  = sel_io_q ? io_byte_q : ram_dout;
    assign tx_valid = (tx_count_q != '0);
    assign tx_data  = tx_mem_q[tx_rd_ptr_q];
    assign halted_o = halted_q;

    // Writes after a program stop are dropped, so halt masks every I/O write source.
    always_comb begin
        is_io         = (mem_addr[17:16] == 2'b11);
        io_off        = mem_addr[2:0];
        wr_io         = mem_wr & is_io & ~halted_q;
        uart_rd       = is_io & (io_off == 3'd0) & mem_re & ~mem_wr;
        rx_stall      = uart_rd & ~rx_valid;
        stop_req      = wr_io & (io_off == 3'd4);
        push_req      = (wr_io & (io_off == 3'd0) & (mem_dout != 8'h00)) | stop_req;
        tx_full       = (tx_count_q == TX_FULL_CNT);
        tx_full_stall = push_req & tx_full;
        cpu_rdy_o     = ~rx_stall & ~tx_full_stall & ~halted_q;
        tx_push       = push_req & ~tx_full;
        push_byte     = stop_req ? 8'h00 : mem_dout;
        tx_pop        = tx_valid & tx_ready;
        rx_pop        = uart_rd & rx_valid & cpu_rdy_o;
        ram_we        = mem_wr & ~is_io & cpu_rdy_o;
    end

    always_comb begin
        case (io_off)
            3'd0:    io_byte = rx_data;
            3'd4:    io_byte = cyc_cnt_q[7:0];
            3'd5:    io_byte = snap_q[15:8];
            3'd6:    io_byte = snap_q[23:16];
            3'd7:    io_byte = snap_q[31:24];
            default: io_byte = 8'h00;
        endcase
    end

    // Read-path registers freeze while the CPU is stalled so the pending result survives.
    always_comb begin
        sel_io_d  = sel_io_q;
        io_byte_d = io_byte_q;
        snap_d    = snap_q;
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        halted_d  = halted_q | (stop_req & tx_push);
        if (cpu_rdy_o) begin
            sel_io_d  = is_io;
            io_byte_d = io_byte;
            if (is_io && io_off == 3'd4 && mem_re && !mem_wr) begin
                snap_d = cyc_cnt_q;
            end
        end
    end

    always_comb begin
        tx_mem_d    = tx_mem_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_ptr_q] = push_byte;
            tx_wr_ptr_d           = tx_wr_ptr_q + 1'b1;
        end
        if (tx_pop) begin
            tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + 1'b1;
            2'b01:   tx_count_d = tx_count_q - 1'b1;
            default: tx_count_d = tx_count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sel_io_q    <= 1'b0;
            io_byte_q   <= 8'h00;
            cyc_cnt_q   <= 32'd0;
            snap_q      <= 32'd0;
            halted_q    <= 1'b0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            tx_mem_q    <= '{default: '0};
        end else begin
            sel_io_q    <= sel_io_d;
            io_byte_q   <= io_byte_d;
            cyc_cnt_q   <= cyc_cnt_d;
            snap_q      <= snap_d;
            halted_q    <= halted_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            tx_mem_q    <= tx_mem_d;
        end
    end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed bench for io_bus_bridge: read results and TX bytes are queued as
// expectations when driven and compared when the bridge produces them.
module tb_io_bus_bridge;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        mem_re;
    logic [7:0]  mem_din;
    logic        cpu_rdy_o;
    logic [16:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halted_o;

    typedef struct {
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t        rd_q[$];
    logic [7:0]  tx_q[$];
    logic        rd_pending = 1'b0;
    logic [31:0] model_cnt;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ram_mem [0:131071];

    io_bus_bridge #(.TX_DEPTH_LOG2(3), .RAM_ADDR_W(17)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_re(mem_re),
        .mem_din(mem_din), .cpu_rdy_o(cpu_rdy_o),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .halted_o(halted_o)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM: read data follows the address by one clock.
    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic [7:0] dout,
                                  input logic wr, input logic re);
        mem_addr = addr;
        mem_dout = dout;
        mem_wr   = wr;
        mem_re   = re;
        #1;
    endtask

    task automatic expect_read(input logic [7:0] v, input string tag);
        rd_q.push_back('{val: v, tag: tag});
        rd_pending = 1'b1;
    endtask

    task automatic check_tx_head(input string tag);
        logic [7:0] e;
        check_output({tag, "_valid"}, 32'(tx_valid), 32'd1);
        if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s observed=byte expected=none_queued", tag);
        end else begin
            e = tx_q.pop_front();
            check_output(tag, 32'(tx_data), 32'(e));
        end
    endtask

    task automatic tick();
        logic was_rst;
        exp_t e;
        was_rst = rst_in;
        @(posedge clk_in);
        #1;
        if (was_rst) model_cnt = 32'd0;
        else         model_cnt = model_cnt + 32'd1;
        if (rd_pending) begin
            e = rd_q.pop_front();
            check_output(e.tag, 32'(mem_din), 32'(e.val));
            rd_pending = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        apply_stimulus(32'h0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        rd_q.delete();
        tx_q.delete();
        rst_in = 1'b0;
        #1;
    endtask

    initial begin
        int guard;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 131072; i++) ram_mem[i] = 8'h00;
        do_reset();
        check_output("rst_rdy", 32'(cpu_rdy_o), 32'd1);
        check_output("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_output("rst_halted", 32'(halted_o), 32'd0);
        check_output("rst_rx_pop", 32'(rx_pop), 32'd0);
        check_output("rst_mem_din_ram", 32'(mem_din), 32'(ram_dout));

        // RAM write then read back.
        apply_stimulus(32'h0000_0100, 8'h5A, 1'b1, 1'b0);
        check_output("ram_we_pulse", 32'(ram_we), 32'd1);
        check_output("ram_addr", 32'(ram_addr), 32'h100);
        check_output("ram_din", 32'(ram_din), 32'h5A);
        tick();
        apply_stimulus(32'h0000_0100, 8'h00, 1'b0, 1'b1);
        check_output("ram_we_drop", 32'(ram_we), 32'd0);
        expect_read(8'h5A, "ram_read");
        tick();

        // UART write, then a zero byte that must not be pushed.
        tx_ready = 1'b1;
        apply_stimulus(32'h0003_0000, 8'h41, 1'b1, 1'b0);
        check_output("io_no_ram_we", 32'(ram_we), 32'd0);
        check_output("tx_empty_before_push", 32'(tx_valid), 32'd0);
        tx_q.push_back(8'h41);
        tick();
        apply_stimulus(32'h0003_0000, 8'h00, 1'b1, 1'b0);
        check_tx_head("uart_tx_41");
        check_output("zero_wr_rdy", 32'(cpu_rdy_o), 32'd1);
        tick();
        apply_stimulus(32'h0, 8'h00, 1'b0, 1'b0);
        check_output("zero_wr_no_push", 32'(tx_valid), 32'd0);

        // Fill the FIFO; the ninth write stalls until one byte drains.
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(32'h0003_0000, 8'(8'h31 + i), 1'b1, 1'b0);
            if (i < 8) begin
                check_output("fill_rdy", 32'(cpu_rdy_o), 32'd1);
                tx_q.push_back(8'(8'h31 + i));
            end else begin
                check_output("full_stall", 32'(cpu_rdy_o), 32'd0);
            end
            tick();
        end
        check_output("full_stall_hold", 32'(cpu_rdy_o), 32'd0);
        tx_ready = 1'b1;
        #1;
        check_output("full_same_cycle_pop", 32'(cpu_rdy_o), 32'd0);
        check_tx_head("drain_first");
        tick();
        tx_ready = 1'b0;
        #1;
        check_output("full_relieved", 32'(cpu_rdy_o), 32'd1);
        tx_q.push_back(8'h39);
        tick();
        apply_stimulus(32'h0, 8'h00, 1'b0, 1'b0);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_tx_head("drain_order");
            tick();
        end
        tx_ready = 1'b0;
        #1;
        check_output("drain_empty", 32'(tx_valid), 32'd0);

        // RX read with no data stalls, then pops exactly once.
        rx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(32'h0003_0000, 8'h00, 1'b0, 1'b1);
            check_output("rx_stall_rdy", 32'(cpu_rdy_o), 32'd0);
            check_output("rx_stall_no_pop", 32'(rx_pop), 32'd0);
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = 8'h7F;
        #1;
        check_output("rx_pop_pulse", 32'(rx_pop), 32'd1);
        check_output("rx_release_rdy", 32'(cpu_rdy_o), 32'd1);
        expect_read(8'h7F, "rx_read_data");
        tick();
        apply_stimulus(32'h0, 8'h00, 1'b0, 1'b0);
        check_output("rx_pop_single", 32'(rx_pop), 32'd0);
        rx_valid = 1'b0;
        apply_stimulus(32'h0003_0000, 8'h00, 1'b0, 1'b0);
        check_output("rx_no_re_rdy", 32'(cpu_rdy_o), 32'd1);
        check_output("rx_no_re_no_pop", 32'(rx_pop), 32'd0);
        tick();

        // Cycle counter bytes read starting 20 cycles after reset release.
        do_reset();
        check_output("post_rst_rdy", 32'(cpu_rdy_o), 32'd1);
        guard = 0;
        while (model_cnt != 32'd20 && guard < 100) begin
            tick();
            guard++;
        end
        apply_stimulus(32'h0003_0004, 8'h00, 1'b0, 1'b1);
        expect_read(8'h14, "cnt_byte0");
        tick();
        apply_stimulus(32'h0003_0005, 8'h00, 1'b0, 1'b1);
        expect_read(8'h00, "cnt_byte1");
        tick();
        apply_stimulus(32'h0003_0006, 8'h00, 1'b0, 1'b1);
        expect_read(8'h00, "cnt_byte2");
        tick();
        apply_stimulus(32'h0003_0007, 8'h00, 1'b0, 1'b1);
        expect_read(8'h00, "cnt_byte3");
        tick();
        apply_stimulus(32'h0003_0002, 8'h00, 1'b0, 1'b1);
        expect_read(8'h00, "io_unmapped");
        tick();

        // Counter wrap from all-ones.
        force dut.cyc_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_cnt_q;
        model_cnt = 32'hFFFF_FFFF;
        apply_stimulus(32'h0003_0004, 8'h00, 1'b0, 1'b1);
        expect_read(8'hFF, "wrap_pre");
        tick();
        apply_stimulus(32'h0003_0004, 8'h00, 1'b0, 1'b1);
        expect_read(8'h00, "wrap_zero");
        tick();
        apply_stimulus(32'h0003_0007, 8'h00, 1'b0, 1'b1);
        expect_read(8'h00, "wrap_snap_top");
        tick();

        // Program stop: halt, emit 0x00, freeze the CPU until reset.
        tx_ready = 1'b0;
        apply_stimulus(32'h0003_0004, 8'hAB, 1'b1, 1'b0);
        check_output("halt_wr_rdy", 32'(cpu_rdy_o), 32'd1);
        tx_q.push_back(8'h00);
        tick();
        check_output("halt_set", 32'(halted_o), 32'd1);
        check_tx_head("halt_tx_zero");
        check_output("halt_rdy_low", 32'(cpu_rdy_o), 32'd0);
        apply_stimulus(32'h0000_0200, 8'h77, 1'b1, 1'b0);
        check_output("halt_no_ram_we", 32'(ram_we), 32'd0);
        tick();
        tick();
        check_output("halt_sticky", 32'(halted_o), 32'd1);
        check_output("halt_no_extra_push", 32'(dut.tx_count_q), 32'd1);
        rst_in = 1'b1;
        apply_stimulus(32'h0, 8'h00, 1'b0, 1'b0);
        tick();
        check_output("rst_clears_halt", 32'(halted_o), 32'd0);
        check_output("rst_clears_tx", 32'(tx_valid), 32'd0);
        rst_in = 1'b0;
        #1;
        check_output("rst_release_rdy", 32'(cpu_rdy_o), 32'd1);
        tick();

        check_output("read_queue_drained", 32'(rd_q.size()), 32'd0);
        check_output("tx_queue_drained", 32'(tx_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_bus_bridge.md
Name: io_bus_bridge

Overview:
- Sits directly downstream of the CPU top's byte-wide memory port and feeds the 128KB RAM and the UART/counter I/O space.
- Decodes each CPU access to RAM or memory-mapped I/O.
- Aligns read data to the CPU's 2-cycle read timing.
- Buffers UART output bytes in a TX FIFO, provides the cycle counter, and latches program stop.
- Deasserts cpu_rdy_o when an I/O access cannot complete.

Parameters:
- TX_DEPTH_LOG2, 3, log2 of TX FIFO depth (8 entries).
- RAM_ADDR_W, 17, RAM byte-address width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- mem_addr  input  32  CPU byte address.
- mem_dout  input  8  CPU write byte.
- mem_wr  input  1  CPU write strobe.
- mem_re  input  1  CPU read strobe; I/O reads have side effects only when high.
- mem_din  output  8  read byte to CPU, valid one cycle after the address.
- cpu_rdy_o  output  1  drives the CPU's rdy_in; low freezes the CPU.
- ram_addr  output  RAM_ADDR_W  RAM address.
- ram_din  output  8  RAM write byte.
- ram_we  output  1  RAM write enable.
- ram_dout  input  8  RAM read byte, synchronous, one cycle after ram_addr.
- rx_data  input  8  UART RX head byte.
- rx_valid  input  1  UART RX non-empty.
- rx_pop  output  1  consume RX head.
- tx_data  output  8  TX FIFO head.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  UART accepts tx_data this cycle.
- halted_o  output  1  sticky program-stop flag.

Behaviour:
- Address decode:
  - is_io = mem_addr[17:16]==2'b11; otherwise RAM.
  - ram_addr = mem_addr[16:0]; ram_din = mem_dout; ram_we = mem_wr & !is_io & cpu_rdy_o.
- I/O offsets (mem_addr[2:0]):
  - 0 = UART.
  - 4..7 = counter bytes 0..3, little-endian.
  - Other offsets read 0x00; writes to them are ignored.
- Read path:
  - Cycle N: register sel_io_q = is_io and io_byte_q = the decoded I/O byte.
  - Cycle N+1: mem_din = sel_io_q ? io_byte_q : ram_dout.
  - When cpu_rdy_o is low in cycle N, sel_io_q and io_byte_q hold their values.
- UART read (offset 0, mem_re=1, !mem_wr):
  - If rx_valid: rx_pop=1 for exactly that cycle, and io_byte_q<=rx_data.
  - Else: cpu_rdy_o=0 until rx_valid rises, then pop as above.
  - With mem_re=0: no pop, no stall.
- UART write (offset 0, mem_wr=1):
  - mem_dout==0x00: ignored, no stall.
  - FIFO not full: push mem_dout.
  - FIFO full: cpu_rdy_o=0 and no push. Full is taken from the registered count; a same-cycle pop does not relieve it. The push happens in the first cycle after count < depth.
- Counter:
  - 32-bit cyc_cnt increments every cycle after reset, independent of cpu_rdy_o; wraps 0xFFFFFFFF->0.
  - A read at offset 4 with mem_re=1 snapshots cyc_cnt into snap and returns cyc_cnt[7:0].
  - Offsets 5..7 return snap[15:8], snap[23:16] and snap[31:24].
- Program stop (write to offset 4):
  - Sets halted_o and pushes 0x00 into the TX FIFO, with the same full-stall rule as a UART write.
  - Once halted_o=1, all further writes are ignored and cpu_rdy_o=0 permanently until reset.
- cpu_rdy_o is combinational: the AND of !rx_stall, !tx_full_stall and !halted_o.
- TX FIFO:
  - Circular buffer with TX_DEPTH_LOG2-bit pointers that wrap naturally, plus a count register.
  - tx_valid = count!=0; a pop occurs on tx_valid & tx_ready.
  - Push and pop in the same cycle leave count unchanged.
  - A byte pushed into an empty FIFO appears on tx_data/tx_valid the next cycle.
- Reset (any cycle, including mid-stall):
  - All pointers, count, cyc_cnt, snap, sel_io_q and io_byte_q go to 0; halted_o=0.
  - Outputs: mem_din=ram_dout (sel_io_q=0), tx_valid=0, rx_pop=0, and cpu_rdy_o=1 the cycle after reset deasserts.

Test Plan:
- RAM access: write 0x5A to 0x00100, then read 0x00100 -> ram_we pulses 1 cycle; mem_din=0x5A one cycle after the read address.
- UART write: write 0x41 to 0x30000 with tx_ready=1 -> tx_valid=1 and tx_data=0x41 the next cycle; a following write of 0x00 -> no push, cpu_rdy_o stays 1.
- FIFO full: tx_ready=0, 9 writes of 0x31..0x39 -> the 9th holds cpu_rdy_o=0. Raise tx_ready for 1 cycle -> 0x31 drains, the next cycle 0x39 is pushed and cpu_rdy_o=1. The drained order is 0x31..0x39.
- RX stall: read 0x30000 with rx_valid=0 for 5 cycles -> cpu_rdy_o=0 throughout. When rx_valid=1 and rx_data=0x7F -> single rx_pop pulse; mem_din=0x7F the next cycle.
- Counter: reset, then read 0x30004..0x30007 starting at cycle 20 after reset release -> bytes 0x14,0x00,0x00,0x00. Force cyc_cnt=0xFFFFFFFF -> the next value is 0.
- Halt: write to 0x30004 -> halted_o=1 next cycle, 0x00 emitted on tx_data, cpu_rdy_o=0. Assert rst_in -> all cleared and cpu_rdy_o=1.
